stim_handshake_gen: RTL and testbench



---
 rtl/stim_handshake_gen.sv | 153 +++++++++++++++
 tb/tb_stim_handshake_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_handshake_gen.sv
// stim_handshake_gen: burst traffic source over validdata/acknowledge
// with run-time pattern select, inter-word gap, ack timeout and retry.
module stim_handshake_gen #(
    parameter int WIDTH = 8,
    parameter int NUM_WORDS = 4,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT = 8,
    parameter int MAX_RETRY = 2,
    parameter logic [WIDTH-1:0] LFSR_POLY = 8'hB8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     mode,
    input  logic [WIDTH-1:0]               seed,
    input  logic                           acknowledge,
    output logic                           validdata,
    output logic [WIDTH-1:0]               data,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(NUM_WORDS+1)-1:0] sent_count
);

    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST  = CW'(NUM_WORDS - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GLAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_GAP, S_RETRY, S_DONE, S_ERROR
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] data_n, seed_q, seed_n;
    logic [WIDTH-1:0] next_word, first_word;
    logic [1:0]       mode_q, mode_n;
    logic [CW-1:0]    cnt_n;
    logic [TW-1:0]    tmo_q, tmo_n;
    logic [RW-1:0]    rty_q, rty_n;
    logic [GW-1:0]    gap_q, gap_n;

    always_comb begin
        first_word = seed;
        if (mode == 2'd3)
            first_word = ONE;
        else if (mode == 2'd2 && seed == '0)
            first_word = ONE;
    end

    always_comb begin
        next_word = data;
        unique case (mode_q)
            2'd0: next_word = data + ONE;
            2'd1: next_word = seed_q;
            2'd2: next_word = data[0] ? ((data >> 1) ^ LFSR_POLY) : (data >> 1);
            default: next_word = {data[WIDTH-2:0], data[WIDTH-1]};
        endcase
    end

    always_comb begin
        state_n = state;
        data_n  = data;
        cnt_n   = sent_count;
        tmo_n   = tmo_q;
        rty_n   = rty_q;
        gap_n   = gap_q;
        mode_n  = mode_q;
        seed_n  = seed_q;
        unique case (state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_n = S_SEND;
                    mode_n  = mode;
                    seed_n  = first_word;
                    data_n  = first_word;
                    cnt_n   = '0;
                    tmo_n   = '0;
                    rty_n   = '0;
                    gap_n   = '0;
                end
            end
            S_SEND: begin
                // an ack on the timeout edge still counts as a transfer
                if (acknowledge) begin
                    cnt_n = sent_count + 1'b1;
                    tmo_n = '0;
                    rty_n = '0;
                    if (sent_count == LAST) begin
                        state_n = S_DONE;
                    end else begin
                        data_n  = next_word;
                        gap_n   = '0;
                        state_n = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
                    end
                end else if (tmo_q == TLAST) begin
                    tmo_n   = '0;
                    state_n = (rty_q == RMAX) ? S_ERROR : S_RETRY;
                end else begin
                    tmo_n = tmo_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GLAST)
                    state_n = S_SEND;
                else
                    gap_n = gap_q + 1'b1;
            end
            S_RETRY: begin
                rty_n   = rty_q + 1'b1;
                state_n = S_SEND;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            data       <= '0;
            seed_q     <= '0;
            mode_q     <= '0;
            sent_count <= '0;
            tmo_q      <= '0;
            rty_q      <= '0;
            gap_q      <= '0;
            validdata  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            data       <= data_n;
            seed_q     <= seed_n;
            mode_q     <= mode_n;
            sent_count <= cnt_n;
            tmo_q      <= tmo_n;
            rty_q      <= rty_n;
            gap_q      <= gap_n;
            validdata  <= (state_n == S_SEND);
            busy       <= (state_n != S_IDLE) && (state_n != S_ERROR);
            done       <= (state_n == S_DONE);
            error      <= (state_n == S_ERROR);
        end
    end

endmodule

// File: tb/tb_stim_handshake_gen.sv
// Bench for stim_handshake_gen: directed bursts, a transaction-level
// word model checked every cycle, and literal timing expectations.
`timescale 1ns/1ps
module tb_stim_handshake_gen;

    localparam int NW  = 4;
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0, ack_a = 1'b0;
    logic [1:0] mode_a = 2'd0;
    logic [7:0] seed_a = 8'h00;
    logic       v_a, busy_a, done_a, err_a;
    logic [7:0] d_a;
    logic [2:0] cnt_a;
    logic       start_b = 1'b0, ack_b = 1'b0;
    logic [1:0] mode_b = 2'd0;
    logic [7:0] seed_b = 8'h00;
    logic       v_b, busy_b, done_b, err_b;
    logic [7:0] d_b;
    logic [2:0] cnt_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stim_handshake_gen dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
        .seed(seed_a), .acknowledge(ack_a), .validdata(v_a),
        .data(d_a), .busy(busy_a), .done(done_a), .error(err_a),
        .sent_count(cnt_a)
    );

    stim_handshake_gen #(.GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
        .seed(seed_b), .acknowledge(ack_b), .validdata(v_b),
        .data(d_b), .busy(busy_b), .done(done_b), .error(err_b),
        .sent_count(cnt_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // expected burst contents, derived from the pattern rules
    logic [7:0] m_words [NW];
    int m_idx = 0;
    int m_gap = 0;
    bit m_done = 1'b0;
    bit m_vnext = 1'b0;

    function automatic void gen(input logic [1:0] m, input logic [7:0] s);
        logic [7:0] w;
        w = (m == 2'd3) ? 8'h01 : ((m == 2'd2 && s == 8'h00) ? 8'h01 : s);
        for (int i = 0; i < NW; i++) begin
            m_words[i] = w;
            case (m)
                2'd0: w = w + 8'd1;
                2'd1: w = s;
                2'd2: w = w[0] ? ((w >> 1) ^ 8'hB8) : (w >> 1);
                default: w = (w << 1) | (w >> 7);
            endcase
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_v", v_a, 0);
            chk("rst_d", d_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_done", done_a, 0);
            chk("rst_err", err_a, 0);
            chk("rst_cnt", cnt_a, 0);
            m_idx = 0;
            m_gap = 0;
            m_done = 1'b0;
            m_vnext = 1'b0;
        end else begin
            chk("m_done", done_a, m_done);
            if (m_done) chk("m_done_v", v_a, 0);
            m_done = 1'b0;
            chk("m_cnt", cnt_a, m_idx);
            if (m_gap > 0) begin
                chk("m_gap_v", v_a, 0);
                m_gap--;
                m_vnext = (m_gap == 0);
            end else if (m_vnext) begin
                chk("m_valid", v_a, 1);
                m_vnext = 1'b0;
            end
            if (v_a && m_idx < NW) chk("m_data", d_a, m_words[m_idx]);
            if (v_a && ack_a) begin
                m_idx++;
                if (m_idx == NW) m_done = 1'b1;
                else m_gap = GAP;
            end
            if (start_a && !busy_a) begin
                gen(mode_a, seed_a);
                m_idx = 0;
                m_vnext = 1'b1;
            end
        end
    end

    task automatic wait_done_a(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done_a) seen = 1'b1;
            else cyc();
        end
        chk({nm, "_done"}, seen, 1);
        chk({nm, "_cnt"}, cnt_a, 4);
        chk({nm, "_err"}, err_a, 0);
        cyc();
    endtask

    task automatic burst_a(input logic [1:0] m, input logic [7:0] s,
                           input logic [31:0] ew, input string nm,
                           input int rep);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        mode_a = m;
        seed_a = s;
        ack_a = 1'b1;
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        chk({nm, "_err0"}, err_a, 0);
        for (int i = 0; i < 60 && !seen; i++) begin
            if (v_a) begin
                if (k < 4) chk({nm, "_w"}, d_a, ew[31-8*k -: 8]);
                k++;
            end
            start_a = (i == rep);
            if (i == rep) seed_a = 8'h99;
            if (done_a) seen = 1'b1;
            else cyc();
        end
        start_a = 1'b0;
        chk({nm, "_done"}, seen, 1);
        chk({nm, "_nw"}, k, 4);
        chk({nm, "_cnt"}, cnt_a, 4);
        cyc();
        chk({nm, "_idle"}, busy_a, 0);
    endtask

    initial begin
        logic [8:0]  vp9;
        logic [5:0]  vp6;
        logic [9:0]  vp10;
        logic [26:0] vp27;
        logic [31:0] ew;
        int k, dn_at, dn_n;

        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("idle_v", v_a, 0);
        chk("idle_busy", busy_a, 0);
        chk("idle_b_v", v_b, 0);

        // defaults: gap of one low cycle between words
        ew = 32'h10111213;
        mode_a = 2'd0; seed_a = 8'h10; ack_a = 1'b1; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        vp9 = '0; k = 0; dn_at = -1; dn_n = 0;
        for (int i = 0; i < 9; i++) begin
            vp9 = {vp9[7:0], v_a};
            if (v_a) begin
                if (k < 4) chk("t1_word", d_a, ew[31-8*k -: 8]);
                k++;
            end
            if (done_a) begin dn_at = i; dn_n++; end
            if (i < 8) cyc();
        end
        chk("t1_vpat", vp9, 9'b101010100);
        chk("t1_nw", k, 4);
        chk("t1_done_at", dn_at, 7);
        chk("t1_done_n", dn_n, 1);
        chk("t1_cnt", cnt_a, 4);
        chk("t1_err", err_a, 0);
        chk("t1_busy", busy_a, 0);

        // back-to-back with wrap
        ew = 32'hFEFF0001;
        mode_b = 2'd0; seed_b = 8'hFE; ack_b = 1'b1; start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        vp6 = '0; k = 0; dn_at = -1;
        for (int i = 0; i < 6; i++) begin
            vp6 = {vp6[4:0], v_b};
            if (v_b) begin
                if (k < 4) chk("t2_word", d_b, ew[31-8*k -: 8]);
                k++;
            end
            if (done_b) dn_at = i;
            if (i < 5) cyc();
        end
        chk("t2_vpat", vp6, 6'b111100);
        chk("t2_nw", k, 4);
        chk("t2_done_at", dn_at, 4);
        chk("t2_cnt", cnt_b, 4);
        chk("t2_err", err_b, 0);

        burst_a(2'd2, 8'h01, 32'h01B85C2E, "t3_lfsr", -1);
        burst_a(2'd2, 8'h00, 32'h01B85C2E, "t3_lfsr0", -1);
        burst_a(2'd3, 8'h55, 32'h01020408, "t3_walk", -1);
        burst_a(2'd1, 8'h5A, 32'h5A5A5A5A, "t3_const", -1);

        // ack held off for one full timeout window on word 0
        mode_a = 2'd0; seed_a = 8'h20; ack_a = 1'b0; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        vp10 = '0;
        for (int i = 0; i < 10; i++) begin
            vp10 = {vp10[8:0], v_a};
            if (v_a) chk("t4_hold", d_a, 8'h20);
            if (i == 8) ack_a = 1'b1;
            if (i < 9) cyc();
        end
        chk("t4_vpat", vp10, 10'b1111111101);
        wait_done_a("t4");

        // no ack at all: three windows then error
        mode_a = 2'd0; seed_a = 8'h33; ack_a = 1'b0; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        vp27 = '0;
        for (int i = 0; i < 27; i++) begin
            vp27 = {vp27[25:0], v_a};
            if (i < 26) cyc();
        end
        chk("t5_vpat", vp27, {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0});
        chk("t5_err", err_a, 1);
        chk("t5_busy", busy_a, 0);
        chk("t5_v", v_a, 0);
        repeat (3) cyc();
        chk("t5_err_hold", err_a, 1);
        chk("t5_d_frz", d_a, 8'h33);
        chk("t5_cnt_frz", cnt_a, 0);
        burst_a(2'd0, 8'h33, 32'h33343536, "t5_rerun", -1);

        // async reset while in the gap after two words
        mode_a = 2'd0; seed_a = 8'h40; ack_a = 1'b1; start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        repeat (3) cyc();
        chk("t6_gap_v", v_a, 0);
        chk("t6_gap_cnt", cnt_a, 2);
        chk("t6_gap_d", d_a, 8'h42);
        rst = 1'b0;
        #1;
        chk("t6_rst_v", v_a, 0);
        chk("t6_rst_d", d_a, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_cnt", cnt_a, 0);
        chk("t6_rst_err", err_a, 0);
        chk("t6_rst_done", done_a, 0);
        cyc();
        rst = 1'b1;
        cyc();
        burst_a(2'd0, 8'h40, 32'h40414243, "t6_rerun", 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
